// File: rtl/hub75_capture_pkg.sv
// hub75_capture_pkg: shared HUB75 capture constants, pixel packing and drain states
package hub75_capture_pkg;
   localparam int COLUMNS = 64;
   localparam int COL_WIDTH = 6;
   localparam int SYNC_STAGES = 2;
   localparam int OE_CNT_WIDTH = 16;
   localparam int PIX_W = 6;
   typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;
   function automatic logic [PIX_W-1:0] pack_pixel(input logic [2:0] rgb1, input logic [2:0] rgb2);
      return {rgb2, rgb1};
   endfunction
endpackage

// File: rtl/hub75_input_sync.sv
// hub75_input_sync: equal-depth synchronizer for the HUB75 pin bus plus rising-edge strobes on the low bits
module hub75_input_sync import hub75_capture_pkg::*; #(
   parameter int W = 13,
   parameter int STAGES = SYNC_STAGES,
   parameter int EDGE_BITS = 2
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic [W-1:0]            d,
   output logic [W-EDGE_BITS-1:0]  data,
   output logic [EDGE_BITS-1:0]    rise
);
   logic [W-1:0] chain [STAGES];
   logic [EDGE_BITS-1:0] prev;
   always_ff @(posedge clk_in) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
         prev <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
         prev <= chain[STAGES-1][EDGE_BITS-1:0];
      end
   end
   assign data = chain[STAGES-1][W-1:EDGE_BITS];
   assign rise = chain[STAGES-1][EDGE_BITS-1:0] & ~prev;
endmodule

// File: rtl/hub75_capture.sv
// hub75_capture: rebuilds latched HUB75 rows into per-column pixel beats and measures #OE on-time
module hub75_capture #(
   parameter int COLUMNS = hub75_capture_pkg::COLUMNS,
   parameter int COL_WIDTH = hub75_capture_pkg::COL_WIDTH,
   parameter int SYNC_STAGES = hub75_capture_pkg::SYNC_STAGES,
   parameter int OE_CNT_WIDTH = hub75_capture_pkg::OE_CNT_WIDTH
) (
   input  logic                    clk_in,
   input  logic                    reset,
   input  logic                    hub_clk_pixel,
   input  logic                    hub_row_latch,
   input  logic                    hub_oe_n,
   input  logic [3:0]              hub_row_addr,
   input  logic [2:0]              hub_rgb1,
   input  logic [2:0]              hub_rgb2,
   input  logic                    status_clear,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              out_row,
   output logic [COL_WIDTH-1:0]    out_column,
   output logic [2:0]              out_rgb1,
   output logic [2:0]              out_rgb2,
   output logic                    out_last,
   output logic [OE_CNT_WIDTH-1:0] oe_on_cycles,
   output logic [7:0]              rows_captured,
   output logic                    overflow,
   output logic                    short_row,
   output logic                    long_row
);
   import hub75_capture_pkg::PIX_W;
   import hub75_capture_pkg::pack_pixel;
   import hub75_capture_pkg::state_t;
   import hub75_capture_pkg::IDLE;
   import hub75_capture_pkg::DRAIN;
   localparam int CW = $clog2(COLUMNS + 2);
   localparam int SW = COLUMNS * PIX_W;
   logic [10:0] sdata;
   logic [1:0] rise;
   logic pix_stb, lat_stb, oe_n_s, hs, acc, drop;
   logic [3:0] addr_s;
   logic [PIX_W-1:0] pix, cur;
   logic [SW-1:0] sreg, sreg_nxt, hold;
   logic [CW-1:0] shift_cnt, shift_cnt_nxt;
   logic [OE_CNT_WIDTH-1:0] oe_cnt;
   logic [COL_WIDTH-1:0] col;
   state_t state, state_nxt;

   hub75_input_sync #(.W(13), .STAGES(SYNC_STAGES), .EDGE_BITS(2)) u_sync (
      .clk_in (clk_in),
      .reset  (reset),
      .d      ({hub_rgb2, hub_rgb1, hub_row_addr, hub_oe_n, hub_row_latch, hub_clk_pixel}),
      .data   (sdata),
      .rise   (rise)
   );

   // The shift lands before any same-cycle latch copy, so the newest pixel is always included
   always_comb begin
      pix_stb = rise[0];
      lat_stb = rise[1];
      oe_n_s = sdata[0];
      addr_s = sdata[4:1];
      pix = pack_pixel(sdata[7:5], sdata[10:8]);
      sreg_nxt = pix_stb ? {pix, sreg[SW-1:PIX_W]} : sreg;
      shift_cnt_nxt = (pix_stb && shift_cnt != CW'(COLUMNS + 1)) ? shift_cnt + 1'b1 : shift_cnt;
      hs = out_valid && out_ready;
      acc = lat_stb && (state == IDLE || (hs && out_last));
      drop = lat_stb && !acc;
   end

   always_ff @(posedge clk_in) state <= !reset ? IDLE : state_nxt;

   always_comb state_nxt = (state == IDLE) ? (acc ? DRAIN : IDLE) : ((hs && out_last && !acc) ? IDLE : DRAIN);

   always_comb begin
      cur = hold[col*PIX_W +: PIX_W];
      out_valid = state == DRAIN;
      out_last = out_valid && col == COL_WIDTH'(COLUMNS - 1);
      out_column = col;
      out_rgb1 = cur[2:0];
      out_rgb2 = cur[5:3];
   end

   always_ff @(posedge clk_in) begin
      if (!reset) begin
         sreg <= '0;
         hold <= '0;
         shift_cnt <= '0;
         oe_cnt <= '0;
         col <= '0;
         out_row <= '0;
         oe_on_cycles <= '0;
         rows_captured <= '0;
         overflow <= 1'b0;
         short_row <= 1'b0;
         long_row <= 1'b0;
      end else begin
         sreg <= sreg_nxt;
         shift_cnt <= lat_stb ? '0 : shift_cnt_nxt;
         oe_cnt <= lat_stb ? '0 : (!oe_n_s && oe_cnt != '1) ? oe_cnt + 1'b1 : oe_cnt;
         col <= (acc || (hs && out_last)) ? '0 : hs ? col + 1'b1 : col;
         if (acc) begin
            hold <= sreg_nxt;
            out_row <= addr_s;
            oe_on_cycles <= oe_cnt;
            rows_captured <= rows_captured + 1'b1;
         end
         overflow <= drop || (overflow && !status_clear);
         short_row <= (acc && shift_cnt_nxt < CW'(COLUMNS)) || (short_row && !status_clear);
         long_row <= (acc && shift_cnt_nxt > CW'(COLUMNS)) || (long_row && !status_clear);
      end
   end
endmodule

// File: tb/tb_hub75_capture.sv
// tb_hub75_capture: randomized HUB75 pin stimulus checked against a sliding-window row model
`timescale 1ns/1ps
module tb_hub75_capture;
   import hub75_capture_pkg::*;
   logic clk_in = 0, reset = 0;
   logic hub_clk_pixel = 0, hub_row_latch = 0, hub_oe_n = 1;
   logic [3:0] hub_row_addr = 0;
   logic [2:0] hub_rgb1 = 0, hub_rgb2 = 0;
   logic status_clear = 0, out_ready = 0;
   logic out_valid, out_last, overflow, short_row, long_row;
   logic [3:0] out_row;
   logic [5:0] out_column;
   logic [2:0] out_rgb1, out_rgb2;
   logic [15:0] oe_on_cycles;
   logic [7:0] rows_captured;
   int errors = 0, checks = 0, ready_mode = 0;
   int rows_m, oe_m, oe_pub, n_shift;
   logic [3:0] row_m;
   logic ov_m, sr_m, lr_m, stalled = 0;
   logic [31:0] bus_prev = 0;
   logic [5:0] win[$];
   logic [31:0] got[$], exp_q[$];

   hub75_capture dut (
      .clk_in(clk_in), .reset(reset), .hub_clk_pixel(hub_clk_pixel), .hub_row_latch(hub_row_latch),
      .hub_oe_n(hub_oe_n), .hub_row_addr(hub_row_addr), .hub_rgb1(hub_rgb1), .hub_rgb2(hub_rgb2),
      .status_clear(status_clear), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_column(out_column), .out_rgb1(out_rgb1), .out_rgb2(out_rgb2), .out_last(out_last),
      .oe_on_cycles(oe_on_cycles), .rows_captured(rows_captured), .overflow(overflow),
      .short_row(short_row), .long_row(long_row)
   );

   initial forever #5 clk_in = ~clk_in;

   initial begin
      #1_500_000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] beat(input logic [3:0] r, input logic [5:0] c, input logic [5:0] px, input logic l);
      return {15'b0, r, c, px, l};
   endfunction

   function automatic logic [31:0] bus();
      return beat(out_row, out_column, {out_rgb2, out_rgb1}, out_last);
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #2;
   endtask

   // Sink: picks out_ready each cycle, records handshaked beats, checks stalled beats hold still
   initial forever begin
      @(negedge clk_in);
      out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
      if (stalled) check("stable_while_stalled", bus(), bus_prev);
      if (out_valid && out_ready) got.push_back(bus());
      stalled = out_valid && !out_ready;
      bus_prev = bus();
   end

   // Synchronizers reset to 0, so #OE reads active for SYNC_STAGES cycles after reset release
   task automatic model_reset();
      win.delete();
      for (int i = 0; i < COLUMNS; i++) win.push_back(6'd0);
      rows_m = 0; oe_m = SYNC_STAGES; oe_pub = 0; n_shift = 0; row_m = 0;
      ov_m = 0; sr_m = 0; lr_m = 0;
      exp_q.delete();
      got.delete();
   endtask

   task automatic shift_px(input logic [5:0] p);
      hub_rgb1 = p[2:0];
      hub_rgb2 = p[5:3];
      hub_clk_pixel = 0;
      repeat (2) tick();
      hub_clk_pixel = 1;
      repeat (2) tick();
      hub_clk_pixel = 0;
      win.push_back(p);
      win.delete(0);
      n_shift++;
   endtask

   task automatic oe_low(input int n);
      hub_oe_n = 0;
      repeat (n) tick();
      hub_oe_n = 1;
      oe_m = (oe_m + n > 65535) ? 65535 : oe_m + n;
   endtask

   task automatic check_flags();
      check("overflow", overflow, ov_m);
      check("short_row", short_row, sr_m);
      check("long_row", long_row, lr_m);
   endtask

   task automatic do_latch(input logic [3:0] row, input bit acc);
      hub_row_addr = row;
      tick();
      hub_row_latch = 1;
      repeat (2) tick();
      hub_row_latch = 0;
      repeat (4) tick();
      if (acc) begin
         rows_m++; oe_pub = oe_m; row_m = row;
         sr_m |= n_shift < COLUMNS;
         lr_m |= n_shift > COLUMNS;
         for (int c = 0; c < COLUMNS; c++) exp_q.push_back(beat(row, 6'(c), win[c], c == COLUMNS - 1));
      end else ov_m = 1;
      oe_m = 0; n_shift = 0;
      check("rows_captured", rows_captured, rows_m % 256);
      check("oe_on_cycles", oe_on_cycles, oe_pub);
      check("out_row", out_row, row_m);
      check_flags();
   endtask

   task automatic wait_beats(input int n);
      int t = 0;
      while (got.size() < n && t < 3000) begin
         tick();
         t++;
      end
      check("beats_arrived", got.size() >= n, 1);
   endtask

   task automatic drain();
      int n;
      wait_beats(exp_q.size());
      repeat (6) tick();
      check("beat_count", got.size(), exp_q.size());
      n = got.size() < exp_q.size() ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) check($sformatf("beat%0d", i), got[i], exp_q[i]);
      got.delete();
      exp_q.delete();
   endtask

   task automatic pulse_clear();
      status_clear = 1;
      tick();
      status_clear = 0;
      tick();
      ov_m = 0; sr_m = 0; lr_m = 0;
      check_flags();
   endtask

   task automatic check_zero();
      check("rst_valid", out_valid, 0);
      check("rst_bus", bus(), 0);
      check("rst_oe", oe_on_cycles, 0);
      check("rst_rows", rows_captured, 0);
      check("rst_flags", {overflow, short_row, long_row}, 0);
   endtask

   initial begin
      logic [5:0] p, p6;
      p6 = 0;
      repeat (3) tick();
      check_zero();
      reset = 1;
      model_reset();
      // row of column indices, row 5, sink always ready
      for (int k = 0; k < COLUMNS; k++) shift_px(6'(k));
      do_latch(4'd5, 1);
      drain();
      // same pattern, #OE low 200 cycles, 10-cycle stall mid-stream
      for (int k = 0; k < COLUMNS; k++) shift_px(6'(k));
      oe_low(200);
      do_latch(4'd9, 1);
      check("oe_200", oe_on_cycles, 200);
      wait_beats(20);
      ready_mode = 2;
      repeat (10) tick();
      ready_mode = 0;
      drain();
      // random rows with random #OE pulses and a random sink
      ready_mode = 1;
      repeat (4) begin
         for (int k = 0; k < COLUMNS; k++) begin
            shift_px(6'($urandom));
            if ($urandom_range(0, 7) == 0) oe_low($urandom_range(1, 40));
         end
         do_latch(4'($urandom), 1);
         drain();
      end
      // second latch while 30 beats still pending
      ready_mode = 2;
      for (int k = 0; k < COLUMNS; k++) shift_px(6'($urandom));
      do_latch(4'd3, 1);
      ready_mode = 0;
      wait_beats(34);
      ready_mode = 2;
      repeat (10) shift_px(6'($urandom));
      do_latch(4'd12, 0);
      ready_mode = 0;
      drain();
      pulse_clear();
      // short row then long row
      for (int k = 0; k < 60; k++) shift_px(6'($urandom));
      do_latch(4'd7, 1);
      drain();
      pulse_clear();
      for (int k = 0; k < 70; k++) begin
         p = 6'($urandom);
         if (k == 6) p6 = p;
         shift_px(p);
      end
      do_latch(4'd10, 1);
      wait_beats(1);
      if (got.size() > 0) check("long_col0", got[0][6:1], p6);
      drain();
      // #OE counter saturation
      oe_low(70000);
      for (int k = 0; k < COLUMNS; k++) shift_px(6'($urandom));
      do_latch(4'd2, 1);
      check("oe_sat", oe_on_cycles, 65535);
      drain();
      // reset at beat 20 of a drain, then a clean row
      for (int k = 0; k < COLUMNS; k++) shift_px(6'($urandom));
      do_latch(4'd4, 1);
      wait_beats(20);
      reset = 0;
      tick();
      check_zero();
      tick();
      reset = 1;
      model_reset();
      for (int k = 0; k < COLUMNS; k++) shift_px(6'(k));
      do_latch(4'd6, 1);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
